// File: rtl/bcd_updown_counter.sv
// Parametrised N-digit BCD up/down counter with parallel load, terminal-count
// flag, registered wrap pulse and per-digit cascade enables.
module bcd_updown_counter #(
    parameter int unsigned DIGITS     = 4,
    parameter bit          CLAMP_LOAD = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cnt_en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   q,
    output logic [DIGITS-2:0]     ena,
    output logic                  tc,
    output logic                  wrap
);

    localparam int unsigned W        = 4 * DIGITS;
    localparam logic [3:0]  DIG_ZERO = 4'd0;
    localparam logic [3:0]  DIG_NINE = 4'd9;

    logic [W-1:0]      q_q;
    logic [W-1:0]      q_d;
    logic              wrap_q;
    logic              wrap_d;
    logic              advance;
    logic [DIGITS:0]   low_nine;
    logic [DIGITS:0]   low_zero;
    logic [DIGITS-1:0] step;

    // Load mapping for a single digit; out-of-range digits go to 9 or 0.
    function automatic logic [3:0] map_load_digit(input logic [3:0] d);
        logic [3:0] r;
        r = d;
        if (d > DIG_NINE) begin
            r = CLAMP_LOAD ? DIG_NINE : DIG_ZERO;
        end
        return r;
    endfunction

    // One decimal step of a single digit; an illegal value recovers to 0.
    function automatic logic [3:0] step_digit(input logic [3:0] d, input logic up);
        logic [3:0] r;
        if (d > DIG_NINE) begin
            r = DIG_ZERO;
        end else if (up) begin
            r = (d == DIG_NINE) ? DIG_ZERO : 4'(d + 4'd1);
        end else begin
            r = (d == DIG_ZERO) ? DIG_NINE : 4'(d - 4'd1);
        end
        return r;
    endfunction

    assign advance = cnt_en & ~load;

    // low_nine[k] / low_zero[k]: every digit below k is 9 / 0 (k=0 is vacuous).
    always_comb begin
        low_nine    = '0;
        low_zero    = '0;
        low_nine[0] = 1'b1;
        low_zero[0] = 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            low_nine[k+1] = low_nine[k] & (q_q[4*k +: 4] == DIG_NINE);
            low_zero[k+1] = low_zero[k] & (q_q[4*k +: 4] == DIG_ZERO);
        end
    end

    // Per-digit step decision, shared by the datapath and the exported enables.
    always_comb begin
        step = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            step[k] = advance & (up_dn ? low_nine[k] : low_zero[k]);
        end
    end

    always_comb begin
        ena = '0;
        for (int unsigned k = 1; k < DIGITS; k++) begin
            ena[k-1] = step[k];
        end
    end

    assign tc = advance & (up_dn ? low_nine[DIGITS] : low_zero[DIGITS]);

    // Next-state: load has priority, otherwise only enabled digits move.
    always_comb begin
        q_d    = q_q;
        wrap_d = tc;
        if (load) begin
            for (int unsigned k = 0; k < DIGITS; k++) begin
                q_d[4*k +: 4] = map_load_digit(load_val[4*k +: 4]);
            end
        end else begin
            for (int unsigned k = 0; k < DIGITS; k++) begin
                if (step[k]) begin
                    q_d[4*k +: 4] = step_digit(q_q[4*k +: 4], up_dn);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign q    = q_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench: directed scenarios on 4-digit builds (both load modes)
// plus randomized 2-digit run against a decimal reference model.
module tb_bcd_updown_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cnt_en, up_dn, load;
    logic [15:0] load_val;
    logic [15:0] q4, q4z;
    logic [2:0]  ena4, ena4z;
    logic        tc4, tc4z, wrap4, wrap4z;

    logic        cnt_en2, up_dn2, load2;
    logic [7:0]  load_val2;
    logic [7:0]  q2;
    logic [0:0]  ena2;
    logic        tc2, wrap2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bcd_updown_counter #(.DIGITS(4), .CLAMP_LOAD(1'b1)) dut4 (
        .clk(clk), .reset(rst_n), .cnt_en(cnt_en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .q(q4), .ena(ena4), .tc(tc4), .wrap(wrap4)
    );

    bcd_updown_counter #(.DIGITS(4), .CLAMP_LOAD(1'b0)) dut4z (
        .clk(clk), .reset(rst_n), .cnt_en(cnt_en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .q(q4z), .ena(ena4z), .tc(tc4z), .wrap(wrap4z)
    );

    bcd_updown_counter #(.DIGITS(2), .CLAMP_LOAD(1'b1)) dut2 (
        .clk(clk), .reset(rst_n), .cnt_en(cnt_en2), .up_dn(up_dn2), .load(load2),
        .load_val(load_val2), .q(q2), .ena(ena2), .tc(tc2), .wrap(wrap2)
    );

    // Decimal reference helpers
    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [31:0] to_bcd(input int v, input int nd);
        logic [31:0] r = '0;
        int x = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int load_dec(input logic [31:0] lv, input int nd, input bit clamp);
        int r = 0;
        int d;
        for (int i = nd - 1; i >= 0; i--) begin
            d = int'(lv[4*i +: 4]);
            if (d > 9) d = clamp ? 9 : 0;
            r = r * 10 + d;
        end
        return r;
    endfunction

    function automatic logic [7:0] exp_ena(input int v, input int nd, input bit en,
                                           input bit ld, input bit up);
        logic [7:0] e = '0;
        int m;
        for (int k = 1; k < nd; k++) begin
            m = pow10(k);
            e[k-1] = en & ~ld & (up ? (v % m == m - 1) : (v % m == 0));
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] e;
        rst_n = 1'b0; cnt_en = 1'b1; up_dn = 1'b0; load = 1'b0; load_val = '0;
        cnt_en2 = 1'b0; up_dn2 = 1'b1; load2 = 1'b0; load_val2 = '0;
        #12;
        n_cmp++; if (q4 !== 16'h0000) begin n_err++; $display("FAIL reset_q got=%h exp=0000", q4); end
        n_cmp++; if (wrap4 !== 1'b0) begin n_err++; $display("FAIL reset_wrap got=%b exp=0", wrap4); end
        n_cmp++; if (tc4 !== 1'b1) begin n_err++; $display("FAIL reset_tc_down got=%b exp=1", tc4); end
        n_cmp++; if (q2 !== 8'h00) begin n_err++; $display("FAIL reset_q2 got=%h exp=00", q2); end
        rst_n = 1'b1;
        load = 1'b1; load_val = 16'h0471; cnt_en = 1'b0;
        tick();
        load = 1'b0; cnt_en = 1'b1; up_dn = 1'b1;
        tick(); tick();
        e = to_bcd(473, 4);
        n_cmp++; if (q4 !== e[15:0]) begin n_err++; $display("FAIL pre_reset_q got=%h exp=%h", q4, e[15:0]); end
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (q4 !== 16'h0000) begin n_err++; $display("FAIL async_reset_q got=%h exp=0000", q4); end
        n_cmp++; if (wrap4 !== 1'b0) begin n_err++; $display("FAIL async_reset_wrap got=%b exp=0", wrap4); end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_count_up();
        logic [7:0]  ee;
        logic [31:0] e;
        cnt_en = 1'b1; up_dn = 1'b1; load = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            ee = exp_ena(i, 4, 1'b1, 1'b0, 1'b1);
            n_cmp++;
            if (ena4 !== ee[2:0]) begin
                n_err++; $display("FAIL count_up_ena step=%0d got=%b exp=%b", i, ena4, ee[2:0]);
            end
            tick();
        end
        e = to_bcd(10, 4);
        n_cmp++; if (q4 !== e[15:0]) begin n_err++; $display("FAIL count_up_q got=%h exp=%h", q4, e[15:0]); end
    endtask

    task automatic test_wrap_up();
        cnt_en = 1'b1; load = 1'b1; load_val = 16'h9998; up_dn = 1'b1;
        tick();
        n_cmp++; if (q4 !== 16'h9998) begin n_err++; $display("FAIL wrap_up_load got=%h exp=9998", q4); end
        load = 1'b0;
        tick();
        n_cmp++; if (q4 !== 16'h9999) begin n_err++; $display("FAIL wrap_up_q9999 got=%h exp=9999", q4); end
        n_cmp++; if (tc4 !== 1'b1) begin n_err++; $display("FAIL wrap_up_tc got=%b exp=1", tc4); end
        n_cmp++; if (ena4 !== 3'b111) begin n_err++; $display("FAIL wrap_up_ena got=%b exp=111", ena4); end
        tick();
        n_cmp++; if (q4 !== 16'h0000) begin n_err++; $display("FAIL wrap_up_q0 got=%h exp=0000", q4); end
        n_cmp++; if (wrap4 !== 1'b1) begin n_err++; $display("FAIL wrap_up_pulse got=%b exp=1", wrap4); end
        tick();
        n_cmp++; if (q4 !== 16'h0001) begin n_err++; $display("FAIL wrap_up_q1 got=%h exp=0001", q4); end
        n_cmp++; if (wrap4 !== 1'b0) begin n_err++; $display("FAIL wrap_up_pulse_end got=%b exp=0", wrap4); end
    endtask

    task automatic test_wrap_down();
        load = 1'b1; load_val = 16'h1000; cnt_en = 1'b1; up_dn = 1'b0;
        tick();
        load = 1'b0;
        #1;
        n_cmp++; if (ena4 !== 3'b111) begin n_err++; $display("FAIL wrap_down_ena got=%b exp=111", ena4); end
        tick();
        n_cmp++; if (q4 !== 16'h0999) begin n_err++; $display("FAIL wrap_down_q0999 got=%h exp=0999", q4); end
        for (int i = 0; i < 999; i++) tick();
        n_cmp++; if (q4 !== 16'h0000) begin n_err++; $display("FAIL wrap_down_q0 got=%h exp=0000", q4); end
        n_cmp++; if (tc4 !== 1'b1) begin n_err++; $display("FAIL wrap_down_tc got=%b exp=1", tc4); end
        tick();
        n_cmp++; if (q4 !== 16'h9999) begin n_err++; $display("FAIL wrap_down_q9999 got=%h exp=9999", q4); end
        n_cmp++; if (wrap4 !== 1'b1) begin n_err++; $display("FAIL wrap_down_pulse got=%b exp=1", wrap4); end
    endtask

    task automatic test_load_clamp();
        logic [31:0] lv;
        logic [31:0] e1, e0;
        lv = 32'h0000_3F5A;
        e1 = to_bcd(load_dec(lv, 4, 1'b1), 4);
        e0 = to_bcd(load_dec(lv, 4, 1'b0), 4);
        load = 1'b1; cnt_en = 1'b1; up_dn = 1'b1; load_val = lv[15:0];
        #1;
        n_cmp++; if (tc4 !== 1'b0) begin n_err++; $display("FAIL load_tc_suppressed got=%b exp=0", tc4); end
        tick();
        n_cmp++; if (q4 !== e1[15:0]) begin n_err++; $display("FAIL load_clamp9 got=%h exp=%h", q4, e1[15:0]); end
        n_cmp++; if (q4z !== e0[15:0]) begin n_err++; $display("FAIL load_clamp0 got=%h exp=%h", q4z, e0[15:0]); end
        n_cmp++; if (wrap4 !== 1'b0) begin n_err++; $display("FAIL load_wrap got=%b exp=0", wrap4); end
        load = 1'b0;
    endtask

    task automatic test_dir_hold();
        load = 1'b1; load_val = 16'h0048; cnt_en = 1'b0;
        tick();
        load = 1'b0; cnt_en = 1'b1; up_dn = 1'b1;
        tick();
        n_cmp++; if (q4 !== 16'h0049) begin n_err++; $display("FAIL dir_up got=%h exp=0049", q4); end
        up_dn = 1'b0;
        tick();
        n_cmp++; if (q4 !== 16'h0048) begin n_err++; $display("FAIL dir_down got=%h exp=0048", q4); end
        cnt_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++;
            if (ena4 !== 3'b000 || tc4 !== 1'b0) begin
                n_err++; $display("FAIL hold_flags cyc=%0d ena=%b tc=%b exp ena=000 tc=0", i, ena4, tc4);
            end
            tick();
            n_cmp++; if (q4 !== 16'h0048) begin n_err++; $display("FAIL hold_q cyc=%0d got=%h exp=0048", i, q4); end
        end
    endtask

    task automatic test_digits2_wrap();
        load2 = 1'b1; load_val2 = 8'h99; cnt_en2 = 1'b1; up_dn2 = 1'b1;
        tick();
        load2 = 1'b0;
        #1;
        n_cmp++; if (tc2 !== 1'b1) begin n_err++; $display("FAIL d2_tc got=%b exp=1", tc2); end
        tick();
        n_cmp++; if (q2 !== 8'h00) begin n_err++; $display("FAIL d2_wrap_q got=%h exp=00", q2); end
        n_cmp++; if (wrap2 !== 1'b1) begin n_err++; $display("FAIL d2_wrap_pulse got=%b exp=1", wrap2); end
        tick();
        n_cmp++; if (wrap2 !== 1'b0) begin n_err++; $display("FAIL d2_wrap_end got=%b exp=0", wrap2); end
    endtask

    task automatic test_random2();
        int          val;
        bit          exp_tc;
        logic [7:0]  ee;
        logic [31:0] e;
        val = int'(q2[7:4]) * 10 + int'(q2[3:0]);
        for (int i = 0; i < 10000; i++) begin
            load2     = ($urandom_range(0, 7) == 0);
            cnt_en2   = ($urandom_range(0, 3) != 0);
            up_dn2    = 1'($urandom_range(0, 1));
            load_val2 = 8'($urandom);
            #1;
            exp_tc = cnt_en2 & ~load2 & (up_dn2 ? (val == 99) : (val == 0));
            ee = exp_ena(val, 2, cnt_en2, load2, up_dn2);
            n_cmp++;
            if (tc2 !== exp_tc || ena2 !== ee[0:0]) begin
                n_err++; $display("FAIL rnd_flags cyc=%0d tc=%b ena=%b exp tc=%b ena=%b", i, tc2, ena2, exp_tc, ee[0]);
            end
            if (load2) val = load_dec({24'h0, load_val2}, 2, 1'b1);
            else if (cnt_en2) val = up_dn2 ? (val + 1) % 100 : (val + 99) % 100;
            tick();
            e = to_bcd(val, 2);
            n_cmp++;
            if (q2 !== e[7:0] || wrap2 !== exp_tc) begin
                n_err++; $display("FAIL rnd_q cyc=%0d q=%h wrap=%b exp q=%h wrap=%b", i, q2, wrap2, e[7:0], exp_tc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap_up();
        test_wrap_down();
        test_load_clamp();
        test_dir_hold();
        test_digits2_wrap();
        test_random2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
